// File: rtl/gpio_regfile_irq.sv
// rtl/gpio_regfile_irq.sv - parametrised GPIO register file with synchronised inputs and edge interrupts
module gpio_regfile_irq #(
  parameter int GPIO_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        addr,
  input  logic [3:0]        wben,
  input  logic              r_wn,
  input  logic [31:0]       wdata,
  input  logic [GPIO_W-1:0] ro_gpio_pinstate,
  output logic [31:0]       rdata,
  output logic [GPIO_W-1:0] rf_gpio_tristate,
  output logic [GPIO_W-1:0] rf_gpio_datareg,
  output logic [GPIO_W-1:0] rf_gpio_interrupt_mask,
  output logic              irq
);

  localparam logic [2:0] ARM_MAX    = 3'(SYNC_STAGES + 1);
  localparam logic [2:0] A_TRISTATE = 3'd0;
  localparam logic [2:0] A_DATAREG  = 3'd1;
  localparam logic [2:0] A_PINSTATE = 3'd2;
  localparam logic [2:0] A_INT_MASK = 3'd3;
  localparam logic [2:0] A_INT_STAT = 3'd4;
  localparam logic [2:0] A_INT_TYPE = 3'd5;
  localparam logic [2:0] A_INT_ANY  = 3'd6;
  localparam logic [2:0] A_TOGGLE   = 3'd7;

  logic [GPIO_W-1:0]             tristate_q, datareg_q, mask_q, status_q, type_q, any_q;
  logic [SYNC_STAGES*GPIO_W-1:0] sync_chain;
  logic [GPIO_W-1:0]             sync_q, prev_q, rise, fall, edge_evt, status_clr;
  logic [2:0]                    arm_cnt;
  logic                          armed;
  logic [31:0]                   byte_mask;
  logic [GPIO_W-1:0]             wmask, wval;
  logic                          wr_en;
  logic [GPIO_W-1:0]             rd_sel;
  logic [31:0]                   rd_ext;
  logic                          unused_hi;

  assign byte_mask = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
  assign wmask     = byte_mask[GPIO_W-1:0];
  assign wval      = wdata[GPIO_W-1:0] & wmask;
  assign wr_en     = ~r_wn & (|wben);
  assign unused_hi = ^{wdata, byte_mask};

  // Oldest slice of the shift chain is the fully synchronised pin value.
  assign sync_q = sync_chain[SYNC_STAGES*GPIO_W-1 -: GPIO_W];
  assign armed  = (arm_cnt == ARM_MAX);
  assign rise   = sync_q & ~prev_q;
  assign fall   = ~sync_q & prev_q;
  assign edge_evt = armed ? ((any_q & (rise | fall)) |
                             (~any_q & ((type_q & fall) | (~type_q & rise)))) : '0;
  assign status_clr = (wr_en && addr == A_INT_STAT) ? wval : '0;

  assign rf_gpio_tristate       = tristate_q;
  assign rf_gpio_datareg        = datareg_q;
  assign rf_gpio_interrupt_mask = mask_q;

  always_comb begin
    rd_sel = '0;
    case (addr)
      A_TRISTATE: rd_sel = tristate_q;
      A_DATAREG:  rd_sel = datareg_q;
      A_PINSTATE: rd_sel = sync_q;
      A_INT_MASK: rd_sel = mask_q;
      A_INT_STAT: rd_sel = status_q;
      A_INT_TYPE: rd_sel = type_q;
      A_INT_ANY:  rd_sel = any_q;
      default:    rd_sel = '0;
    endcase
  end

  always_comb begin
    rd_ext = '0;
    rd_ext[GPIO_W-1:0] = rd_sel;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tristate_q <= '0;
      datareg_q  <= '0;
      mask_q     <= '0;
      status_q   <= '0;
      type_q     <= '0;
      any_q      <= '0;
      sync_chain <= '0;
      prev_q     <= '0;
      arm_cnt    <= '0;
      rdata      <= '0;
      irq        <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[(SYNC_STAGES-1)*GPIO_W-1:0], ro_gpio_pinstate};
      prev_q     <= sync_q;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
      // A new event beats a simultaneous W1C so no edge is ever lost.
      status_q <= (status_q & ~status_clr) | edge_evt;
      irq      <= |(status_q & mask_q);
      if (r_wn) rdata <= rd_ext;
      if (wr_en) begin
        case (addr)
          A_TRISTATE: tristate_q <= (tristate_q & ~wmask) | wval;
          A_DATAREG:  datareg_q  <= (datareg_q & ~wmask) | wval;
          A_INT_MASK: mask_q     <= (mask_q & ~wmask) | wval;
          A_INT_TYPE: type_q     <= (type_q & ~wmask) | wval;
          A_INT_ANY:  any_q      <= (any_q & ~wmask) | wval;
          A_TOGGLE:   datareg_q  <= datareg_q ^ wval;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/gpio_regfile_irq.md
Name: gpio_regfile_irq

Overview:
- Parametrised successor to the fixed 16-bit GPIO register block.
- Provides a configurable-width GPIO register file with byte-enabled writes and registered reads.
- Adds input synchronisation, per-pin edge-detect interrupts (rising/falling/both), write-1-to-clear status, a toggle alias register and a registered interrupt request output.
- Sits between the bus slave decoder and the GPIO pad ring.

Parameters:
GPIO_W, 16, number of GPIO pins; legal range 1..32; register bits above GPIO_W read 0 and ignore writes.
SYNC_STAGES, 2, flip-flop stages on pin inputs; legal range 2..4.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0), one clock domain.
addr  input  3  word address, bus bits [4:2].
wben  input  4  byte write enables, bit n covers wdata[8n+7:8n].
r_wn  input  1  1 = read, 0 = write.
wdata  input  32  write data.
ro_gpio_pinstate  input  GPIO_W  raw asynchronous pad inputs.
rdata  output  32  registered read data.
rf_gpio_tristate  output  GPIO_W  per-pin output enable, 1 = drive.
rf_gpio_datareg  output  GPIO_W  output data register.
rf_gpio_interrupt_mask  output  GPIO_W  interrupt enable mask.
irq  output  1  registered interrupt request.

Behaviour:
- Register map (addr):
  - 0 TRISTATE RW.
  - 1 DATAREG RW.
  - 2 PINSTATE RO, synchronised value.
  - 3 INT_MASK RW.
  - 4 INT_STATUS R/W1C.
  - 5 INT_TYPE RW, 0 = rising, 1 = falling.
  - 6 INT_ANY RW, 1 = both edges, overrides INT_TYPE.
  - 7 DATA_TOGGLE WO, reads 0.
- Write: occurs when r_wn = 0 and wben != 0.
  - Only bytes with wben set are affected; writes take effect at the clock edge.
  - wben = 0 with r_wn = 0 is a no-op.
  - Writes to addr 2 are ignored.
- DATA_TOGGLE write: DATAREG <= DATAREG ^ (wdata masked by byte enables).
- Read: when r_wn = 1, rdata <= zero-extended contents of addr at the clock edge, so data is valid 1 cycle later.
  - rdata holds its value when r_wn = 0.
  - Reads have no side effects, including on INT_STATUS.
- Synchroniser: ro_gpio_pinstate passes through SYNC_STAGES flops to give sync; a further flop gives prev.
  - Pin change reaches PINSTATE readback after SYNC_STAGES cycles and rdata one cycle after that.
- Edge detect per pin i:
  - rise = sync & ~prev; fall = ~sync & prev.
  - event = INT_ANY ? (rise | fall) : (INT_TYPE ? fall : rise).
- INT_STATUS bit i:
  - Set by event[i] regardless of mask.
  - Cleared by a write of 1 to bit i at addr 4 with the byte enabled.
  - Set and clear in the same cycle: set wins (bit stays 1).
- Arming counter: edge detection is suppressed after reset release for SYNC_STAGES+1 cycles so reset-state flops cannot create false events.
  - Implemented as a counter 0..SYNC_STAGES+1; armed when it saturates.
- irq <= |(INT_STATUS & INT_MASK), registered.
  - Asserts 1 cycle after the status bit sets or the mask enables.
  - Deasserts 1 cycle after the clear.
- Changing INT_TYPE/INT_ANY does not alter existing status bits.
- Reset (asynchronous, reset = 0): every register, sync/prev flops, arming counter, rdata and irq go to 0.
  - Reset mid-access aborts the access; no partial write survives.

Test Plan:
- Reset & defaults: hold reset = 0 for 3 cycles, release, read addr 0..7 → rdata = 0x00000000 for each; irq = 0; all rf_* outputs = 0.
- Byte-enable write: write 0xA5A5_1234 to addr 1 with wben = 4'b0001 → rf_gpio_datareg = 0x0034. Then wben = 4'b0010 with 0x0000_5600 → 0x5634. With GPIO_W = 16, read addr 1 → 0x00005634.
- Toggle alias: DATAREG = 0x00FF, write 0x0F0F to addr 7 with wben = 4'b0011 → DATAREG = 0x0FF0. Read addr 7 → 0x00000000.
- Rising-edge interrupt:
  - Mask = 0x0001, pin 0 driven 0→1 → INT_STATUS bit 0 = 1 at SYNC_STAGES+1 cycles after the change; irq = 1 one cycle later.
  - Write 0x1 to addr 4 → status clears and irq drops next cycle.
  - A falling edge on pin 0 sets nothing.
- Both-edges and set/clear collision:
  - INT_ANY = 0x0004; pin 2 toggles 1→0 → status bit 2 sets.
  - Issue a W1C of bit 2 in the same cycle as a new edge event → bit stays 1.
- Reset mid-operation and arming:
  - Assert reset during a write → register stays 0.
  - Release reset with pins held 0xFFFF → INT_STATUS stays 0x0000; no irq.
